// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N up counter.
// Holds the one-shot state enum, width helper and load clamp.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cnt_state_e;

  // Count register width for a given modulus.
  function automatic int cnt_width(input int unsigned modulus);
    return $clog2(modulus);
  endfunction

  // Loads past the top code saturate at modulus-1.
  function automatic int unsigned clamp_load(
    input int unsigned value,
    input int unsigned modulus
  );
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

  localparam int unsigned DEF_MOD = 8;
  localparam int DEF_W = cnt_width(DEF_MOD);

endpackage

// File: rtl/mod_n_up_counter.sv
// Modulo-N up counter with free-run and one-shot modes.
// Ports: clk, rst (async high), en, clr, load, load_val, oneshot,
//   start in; out (count), tc (comb), wrap, done, busy out.
module mod_n_up_counter
  import counter_pkg::*;
#(
  parameter int unsigned MOD_VALUE = DEF_MOD,
  localparam int W = cnt_width(MOD_VALUE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         oneshot,
  input  logic         start,
  output logic [W-1:0] out,
  output logic         tc,
  output logic         wrap,
  output logic         done,
  output logic         busy
);

  localparam logic [W-1:0] MAX = W'(MOD_VALUE - 1);

  logic [W-1:0] r_out;
  cnt_state_e   r_state;
  logic         r_wrap;
  logic         r_done;

  logic [W-1:0] w_out_nxt;
  cnt_state_e   w_state_nxt;
  logic         w_wrap_nxt;
  logic         w_done_nxt;
  logic [W:0]   w_inc;
  logic [W-1:0] w_load;
  logic         w_at_max;

  // One extra bit keeps the increment free of silent overflow.
  assign w_inc = {1'b0, r_out} + (W+1)'(1);
  assign w_load = W'(clamp_load(32'(load_val), MOD_VALUE));
  assign w_at_max = (r_out == MAX);

  always_comb begin
    w_out_nxt   = r_out;
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (clr) begin
      w_out_nxt   = '0;
      w_state_nxt = IDLE;
    end else if (load) begin
      w_out_nxt = w_load;
      if (!oneshot) begin
        w_state_nxt = IDLE;
      end
    end else if (!oneshot) begin
      w_state_nxt = IDLE;
      if (en) begin
        if (w_at_max) begin
          w_out_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_out_nxt = w_inc[W-1:0];
        end
      end
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_out_nxt   = '0;
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (start) begin
            w_out_nxt = '0;
          end else if (en) begin
            if (w_at_max) begin
              // Park on the top code; no wrap in one-shot.
              w_done_nxt  = 1'b1;
              w_state_nxt = DONE;
            end else begin
              w_out_nxt = w_inc[W-1:0];
            end
          end
        end
        default: begin
          w_out_nxt   = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_state <= IDLE;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign out  = r_out;
  assign tc   = w_at_max;
  assign wrap = r_wrap;
  assign done = r_done;
  assign busy = (r_state == RUN);

endmodule

// File: tb/tb_mod_n_up_counter.sv
// Bench for mod_n_up_counter: MOD 8 and MOD 10 builds side by side.
// Directed vector table, hand sequences, random vs. reference model.
module tb_mod_n_up_counter;

  logic clk = 1'b0;
  logic rst;
  logic en, clr, load, oneshot, start;
  logic [2:0] lv8;
  logic [3:0] lv10;
  logic [2:0] out8;
  logic [3:0] out10;
  logic tc8, wrap8, done8, busy8;
  logic tc10, wrap10, done10, busy10;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_n_up_counter #(.MOD_VALUE(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(lv8), .oneshot(oneshot), .start(start),
    .out(out8), .tc(tc8), .wrap(wrap8), .done(done8), .busy(busy8)
  );

  mod_n_up_counter #(.MOD_VALUE(10)) u10 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(lv10), .oneshot(oneshot), .start(start),
    .out(out10), .tc(tc10), .wrap(wrap10), .done(done10), .busy(busy10)
  );

  // Reference model: count as an integer, one-shot as a running flag.
  int m_cnt[2];
  bit m_run[2];
  bit m_wrap[2];
  bit m_done[2];
  int mods[2] = '{8, 10};

  function automatic void chk(string nm, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d exp=%0d", nm, idx, act, exp);
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_run[k] = 0;
      m_wrap[k] = 0;
      m_done[k] = 0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int m;
      int lv;
      m = mods[k];
      lv = (k == 0) ? int'(lv8) : int'(lv10);
      m_wrap[k] = 0;
      m_done[k] = 0;
      if (clr) begin
        m_cnt[k] = 0;
        m_run[k] = 0;
      end else if (load) begin
        m_cnt[k] = (lv < m) ? lv : m - 1;
        if (!oneshot) m_run[k] = 0;
      end else if (!oneshot) begin
        m_run[k] = 0;
        if (en) begin
          m_cnt[k] = (m_cnt[k] + 1) % m;
          m_wrap[k] = (m_cnt[k] == 0);
        end
      end else if (start) begin
        m_cnt[k] = 0;
        m_run[k] = 1;
      end else if (m_run[k] && en) begin
        if (m_cnt[k] + 1 < m) m_cnt[k]++;
        else begin
          m_done[k] = 1;
          m_run[k] = 0;
        end
      end
    end
  endtask

  task automatic model_cmp(int idx);
    chk("m8.out", idx, int'(out8), m_cnt[0]);
    chk("m8.tc", idx, int'(tc8), int'(m_cnt[0] == 7));
    chk("m8.wrap", idx, int'(wrap8), int'(m_wrap[0]));
    chk("m8.done", idx, int'(done8), int'(m_done[0]));
    chk("m8.busy", idx, int'(busy8), int'(m_run[0]));
    chk("m10.out", idx, int'(out10), m_cnt[1]);
    chk("m10.tc", idx, int'(tc10), int'(m_cnt[1] == 9));
    chk("m10.wrap", idx, int'(wrap10), int'(m_wrap[1]));
    chk("m10.done", idx, int'(done10), int'(m_done[1]));
    chk("m10.busy", idx, int'(busy10), int'(m_run[1]));
  endtask

  task automatic step(int idx);
    @(posedge clk);
    model_update();
    #1;
    model_cmp(idx);
  endtask

  typedef struct {
    logic clr, load, en, os, st;
    logic [2:0] lv;
    int eo;
    logic etc, ewr, edn, ebz;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic c, logic l, logic [2:0] lvv,
                             logic e, logic o, logic s, int eo,
                             logic etc, logic ewr, logic edn,
                             logic ebz);
    vec_t r;
    r.clr = c; r.load = l; r.lv = lvv; r.en = e; r.os = o;
    r.st = s; r.eo = eo; r.etc = etc; r.ewr = ewr;
    r.edn = edn; r.ebz = ebz;
    return r;
  endfunction

  task automatic idle_inputs();
    en = 0; clr = 0; load = 0; oneshot = 0; start = 0;
    lv8 = 0; lv10 = 0;
  endtask

  initial begin
    int wraps;
    idle_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out8", 0, int'(out8), 0);
    chk("rst.tc8", 0, int'(tc8), 0);
    chk("rst.wrap8", 0, int'(wrap8), 0);
    chk("rst.done8", 0, int'(done8), 0);
    chk("rst.busy8", 0, int'(busy8), 0);
    chk("rst.out10", 0, int'(out10), 0);
    @(negedge clk);
    rst = 0;

    // Directed table for the MOD 8 build.
    for (int i = 1; i <= 10; i++)
      vq.push_back(v(0,0,0,1,0,0, i % 8, (i % 8) == 7, i == 8, 0, 0));
    vq.push_back(v(0,1,5,1,0,0, 5, 0,0,0,0));
    vq.push_back(v(0,0,0,1,0,0, 6, 0,0,0,0));
    vq.push_back(v(0,0,0,1,0,0, 7, 1,0,0,0));
    vq.push_back(v(0,0,0,1,0,0, 0, 0,1,0,0));
    for (int i = 1; i <= 4; i++)
      vq.push_back(v(0,0,0,1,0,0, i, 0,0,0,0));
    vq.push_back(v(1,1,5,1,0,0, 0, 0,0,0,0));
    vq.push_back(v(0,0,0,1,1,1, 0, 0,0,0,1));
    for (int i = 1; i <= 7; i++)
      vq.push_back(v(0,0,0,1,1,0, i, i == 7, 0, 0, 1));
    vq.push_back(v(0,0,0,1,1,0, 7, 1,0,1,0));
    vq.push_back(v(0,0,0,1,1,0, 7, 1,0,0,0));
    vq.push_back(v(0,0,0,0,1,1, 0, 0,0,0,1));
    vq.push_back(v(0,0,0,1,1,0, 1, 0,0,0,1));
    vq.push_back(v(0,0,0,1,0,0, 2, 0,0,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      clr = vq[i].clr; load = vq[i].load; lv8 = vq[i].lv;
      lv10 = {1'b0, vq[i].lv};
      en = vq[i].en; oneshot = vq[i].os; start = vq[i].st;
      step(100 + i);
      chk("tab.out", i, int'(out8), vq[i].eo);
      chk("tab.tc", i, int'(tc8), int'(vq[i].etc));
      chk("tab.wrap", i, int'(wrap8), int'(vq[i].ewr));
      chk("tab.done", i, int'(done8), int'(vq[i].edn));
      chk("tab.busy", i, int'(busy8), int'(vq[i].ebz));
    end

    // Modulus-10 build: twenty counts from zero wrap twice, never past 9.
    idle_inputs();
    clr = 1;
    step(200);
    clr = 0;
    en = 1;
    wraps = 0;
    for (int i = 1; i <= 20; i++) begin
      step(200 + i);
      chk("m10.seq", i, int'(out10), i % 10);
      chk("m10.range", i, int'(out10 < 4'd10), 1);
      if (wrap10) wraps++;
    end
    chk("m10.wraps", 0, wraps, 2);

    // Clamped load on MOD 10.
    en = 0; load = 1; lv10 = 4'd12; lv8 = 3'd6;
    step(230);
    chk("m10.clamp", 0, int'(out10), 9);
    chk("m10.clamp.tc", 0, int'(tc10), 1);
    chk("m8.load6", 0, int'(out8), 6);

    // Async reset between edges while counting.
    idle_inputs();
    clr = 1;
    step(240);
    clr = 0; en = 1;
    repeat (3) step(241);
    chk("ar.pre", 0, int'(out8), 3);
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("ar.out", 0, int'(out8), 0);
    chk("ar.busy", 0, int'(busy8), 0);
    chk("ar.wrap", 0, int'(wrap8), 0);
    chk("ar.out10", 0, int'(out10), 0);
    @(negedge clk);
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      step(250 + i);
      chk("ar.resume", i, int'(out8), i);
    end

    // Randomized traffic against the model.
    oneshot = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) oneshot = ~oneshot;
      en = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 24) == 0);
      load = ($urandom_range(0, 14) == 0);
      start = ($urandom_range(0, 15) == 0);
      lv8 = 3'($urandom);
      lv10 = 4'($urandom);
      step(1000 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_n_up_counter.md
Name: mod_n_up_counter

Overview:
- Modulo-N binary UP counter, the up-direction counterpart of the existing N-bit down counter.
- Counts 0 -> MOD_VALUE-1, then wraps to 0; supports free-run and one-shot modes.
- Adds synchronous clear, clamped parallel load, terminal-count and wrap outputs for cascading.
- Used as a timebase/prescaler and as the companion block for down-counter-based timers.

Parameters:
MOD_VALUE, 8, counter modulus; legal range >= 2, any value (not restricted to powers of two); W = $clog2(MOD_VALUE)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  count enable; count advances only when high
clr  input  1  synchronous clear (highest functional priority)
load  input  1  synchronous parallel load
load_val  input  W  load value; clamped to MOD_VALUE-1 if >= MOD_VALUE
oneshot  input  1  0 = free-run mode, 1 = one-shot mode
start  input  1  one-shot trigger, single-cycle pulse
out  output  W  current count, registered
tc  output  1  terminal count, combinational: out == MOD_VALUE-1
wrap  output  1  registered one-cycle pulse, high in the cycle out shows 0 after a MOD_VALUE-1 -> 0 wrap
done  output  1  registered one-cycle pulse on one-shot completion
busy  output  1  high while the one-shot FSM is in RUN

Behaviour:
- Reset (async assert, sync-to-clk deassert by the environment): out=0, wrap=0, done=0, state=IDLE, so busy=0 and tc=0.
- Priority each cycle: clr > load > start > count.
- clr: out<=0, state<=IDLE, wrap<=0, done<=0. Applies in both modes.
- load: out<=min(load_val, MOD_VALUE-1); state unchanged; wrap<=0; no counting that cycle.
- Free-run (oneshot=0): state forced to IDLE. If en, out<=(out==MOD_VALUE-1) ? 0 : out+1. The wrap case sets wrap<=1. start is ignored.
- One-shot FSM (oneshot=1), states IDLE, RUN, DONE:
  - IDLE/DONE + start: out<=0, ->RUN. out holds otherwise.
  - RUN + en + out<MOD_VALUE-1: out<=out+1.
  - RUN + en + out==MOD_VALUE-1: out holds MOD_VALUE-1, done<=1, ->DONE. No wrap in one-shot mode.
  - RUN + start: restart, out<=0, stays RUN.
  - RUN + !en: hold.
- Mode change mid-operation:
  - oneshot 1->0: state->IDLE next cycle, free-run resumes from current out.
  - oneshot 0->1: FSM starts in IDLE holding out.
- Latency: one clock from en/clr/load/start sample to the new out value. tc follows out combinationally.
- Arithmetic: the increment is computed W+1 bits wide, no overflow beyond MOD_VALUE-1. For non-power-of-two moduli the codes MOD_VALUE..2^W-1 are never reached.
- Reset mid-count: immediate asynchronous return to reset values; no pulse outputs generated.

Decomposition:
- Shared package counter_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cnt_state_e
  - function clamp_load(value, modulus)
  - localparam helper for W
- No sub-module; a single module with one sequential block plus next-state combinational logic.

Test Plan:
- MOD_VALUE=8, rst pulse, then en=1 for 10 cycles -> out 0,1..7,0,1. tc high at 7. wrap high exactly one cycle when out=0 after 7.
- MOD_VALUE=10, free-run en=1 -> out 0..9,0. Codes 10..15 never appear. wrap asserted once per 10 counts.
- MOD_VALUE=8: load=1 with load_val=5, then en -> out 5,6,7,0. load_val=12 on a MOD_VALUE=10 build -> out=9, tc=1.
- Same cycle clr=1, load=1, en=1 with out=4 -> out=0 next cycle, wrap=0.
- MOD_VALUE=8, oneshot=1, start pulse, en=1 -> busy=1, out 0..7, done pulse one cycle, out holds 7, busy=0. A second start -> out=0, busy=1.
- Assert rst asynchronously mid-count at out=3 (between edges) -> out=0, busy=0, wrap=0 immediately. Release, then en=1 -> counting resumes 1,2,...
